// File: rtl/sid_reg_writer_if.sv
// Requester-side handshakes and synth register bus for sid_reg_writer.
// The master modport is the requester/bench side; slave is the writer itself.
interface sid_reg_writer_if;
    logic       req0_valid;
    logic [2:0] req0_addr;
    logic [1:0] req0_voice;
    logic [7:0] req0_data;
    logic       req0_ready;

    logic       req1_valid;
    logic [2:0] req1_addr;
    logic [1:0] req1_voice;
    logic [7:0] req1_data;
    logic       req1_ready;

    logic [7:0] bus_ctrl;
    logic [7:0] bus_data;
    logic       busy;
    logic       grant_id;
    logic       wr_done;

    modport master (
        output req0_valid, req0_addr, req0_voice, req0_data,
        output req1_valid, req1_addr, req1_voice, req1_data,
        input  req0_ready, req1_ready,
        input  bus_ctrl, bus_data, busy, grant_id, wr_done
    );

    modport slave (
        input  req0_valid, req0_addr, req0_voice, req0_data,
        input  req1_valid, req1_addr, req1_voice, req1_data,
        output req0_ready, req1_ready,
        output bus_ctrl, bus_data, busy, grant_id, wr_done
    );
endinterface

// File: rtl/sid_reg_writer.sv
// Two-requester round-robin arbiter that sequences SID register writes
// through setup / strobe / hold phases timed by a shared down-counter.
//
// state  | meaning
// IDLE   | waiting for a requester; grant and capture payload on acceptance
// SETUP  | address/voice/data driven, strobe low
// STROBE | strobe (bus_ctrl[7]) high
// HOLD   | strobe low, payload still driven; wr_done in the last cycle
module sid_reg_writer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    sid_reg_writer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ptr_q, ptr_d;
    logic       grant_q, grant_d;
    logic [2:0] addr_q, addr_d;
    logic [1:0] voice_q, voice_d;
    logic [7:0] data_q, data_d;
    logic       strobe_q, strobe_d;
    logic       wr_done_q, wr_done_d;

    logic       sel;
    logic       accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            ptr_q     <= 1'b0;
            grant_q   <= 1'b0;
            addr_q    <= 3'd0;
            voice_q   <= 2'd0;
            data_q    <= 8'd0;
            strobe_q  <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            voice_q   <= voice_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            wr_done_q <= wr_done_d;
        end
    end

    always_comb begin
        // A lone valid requester wins regardless of the pointer.
        sel    = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
        accept = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;

        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        voice_d = voice_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    ptr_d   = ~sel;
                    grant_d = sel;
                    addr_d  = sel ? bus.req1_addr  : bus.req0_addr;
                    voice_d = sel ? bus.req1_voice : bus.req0_voice;
                    data_d  = sel ? bus.req1_data  : bus.req0_data;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Strobe and done are registered a cycle ahead so the bus pins come straight from flops.
        strobe_d  = (state_d == STROBE);
        wr_done_d = (state_d == HOLD) && (cnt_d == 4'd0);
    end

    assign bus.req0_ready = accept && !sel;
    assign bus.req1_ready = accept && sel;
    assign bus.bus_ctrl   = {strobe_q, 2'b00, voice_q, addr_q};
    assign bus.bus_data   = data_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_id   = grant_q;
    assign bus.wr_done    = wr_done_q;

endmodule

// File: tb/tb_sid_reg_writer.sv
// Self-checking bench for sid_reg_writer: accepted writes are queued and
// matched against the bus contents at each wr_done pulse.
module tb_sid_reg_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sid_reg_writer_if bus();
    sid_reg_writer_if bp();

    sid_reg_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sid_reg_writer #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_p (
        .clk (clk),
        .rst (rst),
        .bus (bp.slave)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc_n = 0;
    logic [13:0] exp_q[$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_rdy(input int which);
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (which == 0 ? bus.req0_ready : bus.req1_ready) break;
        end
        if (k == 30) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        if (k == 30) check_val("idle_timeout", 32'd0, 32'd1);
    endtask

    // scoreboard: push on handshake, pop and compare on wr_done
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_ready || bus.req1_ready) begin
                check_val("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
                check_val("ready_only_idle", 32'(bus.busy), 32'd0);
            end
            if (bus.req0_ready && bus.req0_valid)
                exp_q.push_back({1'b0, bus.req0_voice, bus.req0_addr, bus.req0_data});
            if (bus.req1_ready && bus.req1_valid)
                exp_q.push_back({1'b1, bus.req1_voice, bus.req1_addr, bus.req1_data});
            if (bus.wr_done) begin
                if (exp_q.size() == 0) begin
                    check_val("wr_done_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [13:0] e;
                    e = exp_q.pop_front();
                    check_val("sb_grant", 32'(bus.grant_id), 32'(e[13]));
                    check_val("sb_ctrl", 32'(bus.bus_ctrl), 32'({3'b000, e[12:11], e[10:8]}));
                    check_val("sb_data", 32'(bus.bus_data), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids[4];
        int tg[4];
        int n;
        logic wd_seen;
        logic [7:0] v_strb, v_busy, v_wd, v_rdy;

        bus.req0_valid = 1'b0; bus.req0_addr = 3'd0; bus.req0_voice = 2'd0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_addr = 3'd0; bus.req1_voice = 2'd0; bus.req1_data = 8'h00;
        bp.req0_valid  = 1'b0; bp.req0_addr  = 3'd0; bp.req0_voice  = 2'd0; bp.req0_data  = 8'h00;
        bp.req1_valid  = 1'b0; bp.req1_addr  = 3'd0; bp.req1_voice  = 2'd0; bp.req1_data  = 8'h00;

        // reset values, with a requester already valid
        repeat (2) tick();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h09;
        smp();
        check_val("rst_ctrl", 32'(bus.bus_ctrl), 32'h00);
        check_val("rst_data", 32'(bus.bus_data), 32'h00);
        check_val("rst_grant", 32'(bus.grant_id), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_wr_done", 32'(bus.wr_done), 32'd0);
        check_val("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check_val("rst_ready1", 32'(bus.req1_ready), 32'd0);

        // single write at defaults; first grant right after release
        tick(); rst = 1'b0;
        smp();
        check_val("s1_ready0", 32'(bus.req0_ready), 32'd1);
        check_val("s1_busy_idle", 32'(bus.busy), 32'd0);
        tick(); smp();
        check_val("s1_setup_ready0", 32'(bus.req0_ready), 32'd0);
        check_val("s1_setup_ctrl", 32'(bus.bus_ctrl), 32'h00);
        check_val("s1_setup_data", 32'(bus.bus_data), 32'h09);
        check_val("s1_setup_busy", 32'(bus.busy), 32'd1);
        tick(); smp();
        check_val("s1_strobe1_ctrl", 32'(bus.bus_ctrl), 32'h80);
        tick(); smp();
        check_val("s1_strobe2_ctrl", 32'(bus.bus_ctrl), 32'h80);
        check_val("s1_strobe2_wr_done", 32'(bus.wr_done), 32'd0);
        tick(); bus.req0_valid = 1'b0;
        smp();
        check_val("s1_hold_ctrl", 32'(bus.bus_ctrl), 32'h00);
        check_val("s1_hold_wr_done", 32'(bus.wr_done), 32'd1);
        tick(); smp();
        check_val("s1_idle_wr_done", 32'(bus.wr_done), 32'd0);
        check_val("s1_idle_busy", 32'(bus.busy), 32'd0);
        check_val("s1_idle_data", 32'(bus.bus_data), 32'h09);

        // contention from reset: order 0,1,0,1 every 5 cycles
        tick(); rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_voice = 2'd1; bus.req0_data = 8'h11;
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_voice = 2'd2; bus.req1_data = 8'h22;
        tick(); rst = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            smp();
            if (bus.req0_ready || bus.req1_ready) begin
                ids[n] = bus.req1_ready ? 1 : 0;
                tg[n]  = cyc_n;
                n++;
            end
        end
        tick(); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        check_val("rr_count", 32'(n), 32'd4);
        if (n == 4) begin
            for (int i = 0; i < 4; i++) check_val("rr_order", 32'(ids[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) check_val("rr_period", 32'(tg[i] - tg[i-1]), 32'd5);
        end
        wait_idle();

        // filter-bank write from requester 1
        tick();
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd3; bus.req1_voice = 2'd3; bus.req1_data = 8'h1F;
        wait_rdy(1);
        tick(); bus.req1_valid = 1'b0;
        smp();
        check_val("flt_setup_ctrl", 32'(bus.bus_ctrl), 32'h1B);
        check_val("flt_setup_data", 32'(bus.bus_data), 32'h1F);
        check_val("flt_grant", 32'(bus.grant_id), 32'd1);
        smp();
        check_val("flt_strobe_ctrl", 32'(bus.bus_ctrl), 32'h9B);
        wait_idle();

        // payload stability after acceptance
        tick();
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd5; bus.req0_voice = 2'd2; bus.req0_data = 8'h24;
        wait_rdy(0);
        tick(); bus.req0_data = 8'hFF; bus.req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            check_val("stable_data", 32'(bus.bus_data), 32'h24);
        end
        check_val("stable_wr_done", 32'(bus.wr_done), 32'd1);
        wait_idle();

        // reset during STROBE aborts the write
        tick();
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd6; bus.req0_voice = 2'd1; bus.req0_data = 8'h5A;
        wait_rdy(0);
        tick(); bus.req0_valid = 1'b0;
        smp();
        smp();
        check_val("abort_strobe_ctrl", 32'(bus.bus_ctrl), 32'h8E);
        #2 rst = 1'b1;
        #1;
        check_val("abort_ctrl", 32'(bus.bus_ctrl), 32'h00);
        check_val("abort_data", 32'(bus.bus_data), 32'h00);
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        wd_seen = 1'b0;
        repeat (3) begin
            smp();
            wd_seen = wd_seen | bus.wr_done;
        end
        tick(); rst = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_voice = 2'd0; bus.req1_data = 8'h33;
        wait_rdy(1);
        tick(); bus.req1_valid = 1'b0;
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                smp();
                if (bus.wr_done) break;
            end
            check_val("abort_new_write_done", 32'(k < 20), 32'd1);
        end
        check_val("abort_no_wr_done", 32'(wd_seen), 32'd0);
        wait_idle();

        // 2/3/2 timing instance: 8-cycle window after the first grant
        tick();
        bp.req0_valid = 1'b1; bp.req0_addr = 3'd1; bp.req0_voice = 2'd0; bp.req0_data = 8'h42;
        begin
            int k;
            for (k = 0; k < 30; k++) begin
                smp();
                if (bp.req0_ready) break;
            end
            check_val("par_first_ready", 32'(k < 30), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            smp();
            v_strb[i] = bp.bus_ctrl[7];
            v_busy[i] = bp.busy;
            v_wd[i]   = bp.wr_done;
            v_rdy[i]  = bp.req0_ready;
        end
        tick(); bp.req0_valid = 1'b0;
        check_val("par_strobe", 32'(v_strb), 32'h1C);
        check_val("par_busy", 32'(v_busy), 32'h7F);
        check_val("par_wr_done", 32'(v_wd), 32'h40);
        check_val("par_period", 32'(v_rdy), 32'h80);

        repeat (15) tick();
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sid_reg_writer.md
SID_REG_WRITER -- requirements
Module: sid_reg_writer

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles the address, voice and data are driven with the strobe low before the strobe rises; legal range 1..15.
REQ-002 Parameter STROBE_CYC, default 2: cycles the strobe (bus_ctrl[7]) is held high; legal range 1..15.
REQ-003 Parameter HOLD_CYC, default 1: cycles the address and data stay driven with the strobe low after the strobe falls; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req0_valid  input  1  requester 0 has a register write pending.
REQ-007 req0_addr / req0_voice / req0_data  input  3/2/8  requester 0 register address, voice select (3 = filter bank) and data byte.
REQ-008 req0_ready  output  1  requester 0 write accepted this cycle (valid && ready = transfer).
REQ-009 req1_valid, req1_addr, req1_voice, req1_data, req1_ready: identical to REQ-006..REQ-008, for requester 1.
REQ-010 bus_ctrl  output  8  {strobe, 2'b00, voice[1:0], addr[2:0]}; connects to the synth control-input port.
REQ-011 bus_data  output  8  data byte; connects to the synth bidirectional-input port.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant_id  output  1  index of the requester whose write is on the bus; held after completion.
REQ-014 wr_done  output  1  one-cycle pulse in the final HOLD cycle of each write.

Function
REQ-015 FSM states IDLE, SETUP, STROBE, HOLD; a 4-bit down-counter times each phase.
REQ-016 IDLE: the FSM picks one requester with valid high, using round-robin.
- The selected requester's ready is asserted combinationally in the same cycle.
- Its addr, voice and data are captured at that rising edge.
- The FSM enters SETUP.
REQ-017 Round-robin:
- pointer = requester with priority; reset value is requester 0.
- Pointer moves to the other requester after every grant.
- If only one requester is valid, it is granted regardless of the pointer.
REQ-018 SETUP lasts SETUP_CYC cycles.
- bus_ctrl = {0, 00, voice, addr}.
- bus_data = captured data.
REQ-019 STROBE lasts STROBE_CYC cycles: bus_ctrl[7] = 1; all other bus bits unchanged.
REQ-020 HOLD lasts HOLD_CYC cycles: bus_ctrl[7] = 0; other bits unchanged; wr_done is pulsed in the last HOLD cycle; the next state is IDLE.
REQ-021 Ready is never asserted outside IDLE; at most one ready is high in any cycle.
REQ-022 In IDLE, bus_ctrl[6:0] and bus_data keep the last transaction's values, and bus_ctrl[7] = 0.
REQ-023 Back-to-back issue period is 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles (5 at defaults).
REQ-024 Captured payload is immune to requester input changes after acceptance.
REQ-025 bus_ctrl, bus_data, grant_id and wr_done are driven from registers (no combinational path from requester inputs).
REQ-026 bus_ctrl[6:5] are always 0.

Reset
REQ-027 While rst is high, the block SHALL be held in this state:
- state = IDLE; counter = 0; pointer = requester 0.
- bus_ctrl = 0x00; bus_data = 0x00; grant_id = 0.
- busy = 0; wr_done = 0; both ready = 0.
REQ-028 rst asserted mid-transaction aborts it immediately: the strobe drops asynchronously, and the write in flight is lost and not reported by wr_done.
REQ-029 First grant is permitted in the first clock edge after rst deasserts.

Verification
REQ-030 Single write, defaults: req0 addr=0, voice=0, data=0x09, held valid.
- req0_ready high for exactly one cycle.
- Then 1 cycle with bus_ctrl=0x00 and bus_data=0x09.
- Then 2 cycles with bus_ctrl=0x80.
- Then 1 cycle with bus_ctrl=0x00 and wr_done=1.
REQ-031 Contention: both requesters valid continuously after reset.
- Grant order is 0,1,0,1.
- Successive ready pulses are 5 cycles apart.
- Each bus transaction carries its own requester's payload.
REQ-032 Filter write: req1 addr=3, voice=3, data=0x1F.
- During SETUP, bus_ctrl=0x1B and bus_data=0x1F.
- During STROBE, bus_ctrl=0x9B.
- grant_id=1.
REQ-033 Payload stability: req0 data changes from 0x24 to 0xFF in the cycle after acceptance; bus_data remains 0x24 through HOLD.
REQ-034 Reset during STROBE:
- bus_ctrl=0x00 and bus_data=0x00 with no clock edge.
- No wr_done is seen.
- A new write after release completes normally.
REQ-035 Parameters SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2: phase lengths are 2/3/2 cycles, and the issue period is 8 cycles.
